// File: rtl/cpu_pkg.sv
// Constants and types shared by the Spartan CPU core (fetch, memory, decode).
package cpu_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    // One prefetched instruction word together with the address it came from.
    typedef struct packed {
        logic [DATA_W-1:0] word;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with push, pop and flush; flush beats push and pop.
// The head reads as zero while empty so downstream never sees stale storage.
module fetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic [PTR_W:0]   count
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             not_empty;
    logic             do_push;
    logic             do_pop;

    assign not_empty = (count != '0);
    assign do_push   = push & ~flush;
    assign do_pop    = pop & not_empty & ~flush;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so
    // stale contents are never observable and the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr] <= push_data;
    end

    assign head = not_empty ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: drives the instruction port, captures the
// one-cycle-latent i_bus word and queues {word, pc} for decode.
module fetch_unit #(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter int                DATA_W   = cpu_pkg::DATA_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_bus,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W+1:0] DEPTH_V = (PTR_W+2)'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] word;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inf_pc;
    logic              inf_v;
    logic [PTR_W:0]    count;
    logic [PTR_W+1:0]  occupancy;
    logic              pop;
    logic              issue;
    entry_t            push_entry;
    entry_t            head_entry;

    assign i_addr = fetch_pc;
    assign pop    = instr_valid & instr_ready;

    // Occupancy after this edge: queued words, plus the word landing now,
    // minus the one decode takes now. Issue only if that leaves room.
    assign occupancy = (PTR_W+2)'(count) + (PTR_W+2)'(inf_v) - (PTR_W+2)'(pop);
    assign issue     = ~redirect & (occupancy < DEPTH_V);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            inf_v    <= 1'b0;
            inf_pc   <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            inf_v    <= 1'b0;
        end else if (issue) begin
            fetch_pc <= fetch_pc + ADDR_W'(1);
            inf_v    <= 1'b1;
            inf_pc   <= fetch_pc;
        end else begin
            inf_v    <= 1'b0;
        end
    end

    assign push_entry = '{word: i_bus, pc: inf_pc};

    fetch_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (inf_v),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .count     (count)
    );

    assign instr_valid = (count != '0);
    assign instr       = head_entry.word;
    assign instr_pc    = head_entry.pc;

endmodule
